// File: rtl/sdrd_pkg.sv
// Shared definitions for the SDRD serial path: FSM states, default sizing and the
// bus-cycle qualification decode used by both the sequencer and the deserializer.
package sdrd_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int WIDTH_DEF        = 8;
  localparam int IDLE_TIMEOUT_DEF = 16;

  // Select decode shared with the sequencer so both sides agree on which cycles carry SDRD.
  function automatic logic qual_decode(input logic sser_n, input logic ba13,
                                       input logic ba12, input logic br_w);
    return ~sser_n & ~ba13 & ba12 & br_w;
  endfunction

endpackage

// File: rtl/sdrd_hold_reg.sv
// One-word valid/ready holding register. A load into a full, non-draining register is
// dropped and raises a sticky overflow flag.
module sdrd_hold_reg
  import sdrd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             ovf
);

  logic drop;

  assign drop = load & valid & ~ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      // A load in the same cycle the held word is taken refills without a bubble.
      if (load && (!valid || ready)) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      ovf <= drop | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: rtl/sdrd_deserializer.sv
// Samples the SDRD bit stream on qualified bus cycles, assembles LSB-first words and
// hands them to a holding register; aborts stalled partial words with a frame_err pulse.
module sdrd_deserializer
  import sdrd_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sser_n,
  input  logic             ba13,
  input  logic             ba12,
  input  logic             br_w,
  input  logic             sdrd_oe,
  input  logic             sdrd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       bit_cnt,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic             frame_err
);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_next;
  logic [7:0]       idle_cnt;
  logic             qual;
  logic             complete;

  assign qual = qual_decode(sser_n, ba13, ba12, br_w) & sdrd_oe;

  // NOTE: always_comb outputs are assigned on every path so no latch can be inferred.
  always_comb begin
    shift_next = {sdrd, shreg[WIDTH-1:1]};
    complete   = qual && (bit_cnt == 4'(WIDTH - 1));
  end

  // NOTE: the datapath shift register is reset as well, so an aborted word leaves no residue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (qual) begin
        idle_cnt <= '0;
        if (complete) begin
          shreg   <= '0;
          bit_cnt <= '0;
          state   <= IDLE;
        end else begin
          shreg   <= shift_next;
          bit_cnt <= bit_cnt + 4'd1;
          state   <= SHIFT;
        end
      end else if (state == SHIFT) begin
        // Only a stall inside a word counts; an idle bus between words is normal.
        if (idle_cnt == 8'(IDLE_TIMEOUT - 1)) begin
          idle_cnt  <= '0;
          shreg     <= '0;
          bit_cnt   <= '0;
          state     <= IDLE;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 8'd1;
        end
      end
    end
  end

  sdrd_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (complete),
    .load_data (shift_next),
    .ready     (out_ready),
    .ovf_clr   (ovf_clr),
    .data      (out_data),
    .valid     (out_valid),
    .ovf       (ovf)
  );

endmodule

// File: tb/tb_sdrd_deserializer.sv
// Self-checking bench for sdrd_deserializer: directed scenarios followed by random traffic,
// every cycle compared against a word-level reference model.
module tb_sdrd_deserializer;

  localparam int W  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n, sser_n, ba13, ba12, br_w, sdrd_oe, sdrd, out_ready, ovf_clr;
  logic [W-1:0] out_data;
  logic         out_valid, ovf, frame_err;
  logic [3:0]   bit_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: partial word as a count plus accumulated value, one-slot holding buffer.
  int m_cnt, m_acc, m_idle, m_hdata;
  bit m_hval, m_ovf, m_ferr;

  always #5 clk = ~clk;

  sdrd_deserializer #(.WIDTH(W), .IDLE_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sser_n    (sser_n),
    .ba13      (ba13),
    .ba12      (ba12),
    .br_w      (br_w),
    .sdrd_oe   (sdrd_oe),
    .sdrd      (sdrd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bit_cnt   (bit_cnt),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance the model using the inputs currently applied, clock once, compare every output.
  task automatic tick();
    bit q, done, set_ovf;
    int word;
    done    = 0;
    set_ovf = 0;
    word    = 0;
    if (!rst_n) begin
      m_cnt = 0; m_acc = 0; m_idle = 0; m_hdata = 0;
      m_hval = 0; m_ovf = 0; m_ferr = 0;
    end else begin
      q      = !sser_n && !ba13 && ba12 && br_w && sdrd_oe;
      m_ferr = 0;
      if (q) begin
        m_acc  = m_acc | (int'(sdrd) << m_cnt);
        m_cnt  = m_cnt + 1;
        m_idle = 0;
        if (m_cnt == W) begin
          done  = 1;
          word  = m_acc;
          m_cnt = 0;
          m_acc = 0;
        end
      end else if (m_cnt > 0) begin
        m_idle = m_idle + 1;
        if (m_idle == TO) begin
          m_ferr = 1;
          m_cnt  = 0;
          m_acc  = 0;
          m_idle = 0;
        end
      end
      if (m_hval && out_ready) m_hval = 0;
      if (done) begin
        if (!m_hval) begin
          m_hval  = 1;
          m_hdata = word;
        end else begin
          set_ovf = 1;
        end
      end
      m_ovf = set_ovf || (m_ovf && !ovf_clr);
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_hval));
    check("out_data",  32'(out_data),  32'(m_hdata));
    check("bit_cnt",   32'(bit_cnt),   32'(m_cnt));
    check("ovf",       32'(ovf),       32'(m_ovf));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic bus_qual();
    sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1; sdrd_oe = 1'b1;
  endtask

  task automatic send_bit(input logic d);
    bus_qual();
    sdrd = d;
    tick();
  endtask

  task automatic idle_clk();
    bus_qual();
    sser_n = 1'b1;
    sdrd   = 1'($urandom);
    tick();
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_bit(w[i]);
  endtask

  initial begin
    logic [W-1:0] w;
    int dens;

    rst_n = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; sdrd = 1'b0;
    bus_qual();
    sser_n = 1'b1;

    // 1: reset state, then the 1,0,1,1,0,0,1,0 stream -> 8'h4D
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_cnt",   32'(bit_cnt),   32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    w = 8'h4D;
    for (int i = 0; i < W - 1; i++) begin
      send_bit(w[i]);
      check("t1_not_yet", 32'(out_valid), 32'd0);
    end
    send_bit(w[W-1]);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data",  32'(out_data),  32'h4D);
    check("t1_ovf",   32'(ovf),       32'd0);
    idle_clk();
    check("t1_drain", 32'(out_valid), 32'd0);

    // 2: disqualified clock in mid-word (ba13 once, sdrd_oe once) is ignored
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 3; i++) send_bit(w[i]);
      bus_qual();
      if (v == 0) ba13 = 1'b1;
      else        sdrd_oe = 1'b0;
      sdrd = ~w[3];
      tick();
      check("t2_cnt_hold", 32'(bit_cnt), 32'd3);
      for (int i = 3; i < W; i++) send_bit(w[i]);
      check("t2_data",  32'(out_data),  32'h4D);
      check("t2_valid", 32'(out_valid), 32'd1);
      idle_clk();
    end

    // 3: overflow with consumer stalled, ovf_clr, drain; then clear-vs-set collision
    out_ready = 1'b0;
    send_word(8'hA5);
    check("t3_first", 32'(out_data), 32'hA5);
    send_word(8'h3C);
    check("t3_held",  32'(out_data), 32'hA5);
    check("t3_ovf",   32'(ovf),      32'd1);
    ovf_clr = 1'b1;
    idle_clk();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(ovf), 32'd0);
    out_ready = 1'b1;
    idle_clk();
    check("t3_drop", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    send_word(8'h5A);
    w = 8'hC6;
    for (int i = 0; i < W - 1; i++) send_bit(w[i]);
    ovf_clr = 1'b1;
    send_bit(w[W-1]);
    ovf_clr = 1'b0;
    check("t3_set_wins", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; out_ready = 1'b1;
    idle_clk();
    ovf_clr = 1'b0;

    // 4: stall timeout mid-word, fresh word after, idle bus never flags
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    for (int i = 1; i < TO; i++) begin
      idle_clk();
      check("t4_no_err_yet", 32'(frame_err), 32'd0);
    end
    idle_clk();
    check("t4_ferr", 32'(frame_err), 32'd1);
    check("t4_cnt0", 32'(bit_cnt),   32'd0);
    idle_clk();
    check("t4_pulse", 32'(frame_err), 32'd0);
    send_word(8'h96);
    check("t4_fresh", 32'(out_data), 32'h96);
    for (int i = 0; i < 40; i++) begin
      idle_clk();
      check("t4_idle_quiet", 32'(frame_err), 32'd0);
    end

    // 5: second completion on the cycle the first word is accepted -> no bubble
    send_word(8'h11);
    out_ready = 1'b0;
    w = 8'h22;
    for (int i = 0; i < W - 1; i++) begin
      send_bit(w[i]);
      check("t5_hold", 32'(out_data), 32'h11);
    end
    out_ready = 1'b1;
    send_bit(w[W-1]);
    check("t5_valid", 32'(out_valid), 32'd1);
    check("t5_data",  32'(out_data),  32'h22);
    check("t5_ovf",   32'(ovf),       32'd0);
    idle_clk();
    check("t5_drain", 32'(out_valid), 32'd0);

    // 6: reset with a held word and a partial word pending
    out_ready = 1'b0;
    send_word(8'hE7);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst_n = 1'b0;
    idle_clk();
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data",  32'(out_data),  32'd0);
    check("t6_cnt",   32'(bit_cnt),   32'd0);
    rst_n = 1'b1;
    send_word(8'h0C);
    check("t6_clean", 32'(out_data), 32'h0C);

    // Random traffic with varying bus density so timeouts, overflows and resets all occur
    dens = 90;
    for (int c = 0; c < 4000; c++) begin
      if (c % 97 == 0) begin
        case ($urandom_range(0, 3))
          0:       dens = 95;
          1:       dens = 60;
          2:       dens = 10;
          default: dens = 0;
        endcase
      end
      rst_n = ($urandom_range(0, 499) != 0);
      bus_qual();
      if ($urandom_range(0, 99) >= dens) begin
        case ($urandom_range(0, 4))
          0:       sser_n  = 1'b1;
          1:       ba13    = 1'b1;
          2:       ba12    = 1'b0;
          3:       br_w    = 1'b0;
          default: sdrd_oe = 1'b0;
        endcase
      end
      sdrd      = 1'($urandom);
      out_ready = ($urandom_range(0, 99) < 60);
      ovf_clr   = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
